ctu_dbgbus_arb: RTL and testbench
=================================

CTU_DBGBUS_ARB -- requirements
Module: ctu_dbgbus_arb

Interface
REQ-001 Parameter DW, default 40, debug-bus payload width.
REQ-002 Parameter CNTW, default 8, width of the drop counter.
REQ-003 rclk  input  1  the block's single clock; all flops rising-edge.
REQ-004 arst_l  input  1  asynchronous, active-low reset.
REQ-005 dbg_en  input  1  global enable; low forces the arbiter idle.
REQ-006 burst_len  input  4  maximum consecutive grant cycles per source while the other source is requesting; 0 means unlimited.
REQ-007 b0_data  input  DW  source 0 payload.
REQ-008 b0_vld  input  1  source 0 payload valid.
REQ-009 b1_data  input  DW  source 1 payload.
REQ-010 b1_vld  input  1  source 1 payload valid.
REQ-011 drop_clr  input  1  synchronous clear of drop_cnt.
REQ-012 b0_gnt  output  1  source 0 owns the bus this cycle (registered state decode).
REQ-013 b1_gnt  output  1  source 1 owns the bus this cycle.
REQ-014 dbgbus_out  output  DW  registered selected payload.
REQ-015 dbgbus_vld  output  1  registered, qualifies dbgbus_out.
REQ-016 dbgbus_src  output  1  registered source id of dbgbus_out (0/1).
REQ-017 drop_cnt  output  CNTW  saturating count of valid-but-ungranted source cycles.

Function
REQ-018 FSM states IDLE, GNT0, GNT1; b0_gnt=1 only in GNT0, b1_gnt=1 only in GNT1.
REQ-019 Source x is accepted in cycle n when FSM is GNTx and bx_vld=1 in cycle n.
REQ-020 Accepted payload appears on dbgbus_out with dbgbus_vld=1 and dbgbus_src=x at cycle n+1 (latency 1); otherwise dbgbus_vld=0 at n+1 and dbgbus_out/dbgbus_src hold their previous values.
REQ-021 IDLE: one source valid -> GNT of that source; both valid -> GNT of the source not equal to last_owner; none -> stay IDLE.
REQ-022 GNTx, bx_vld=0: go GNTy if other source y valid, else IDLE.
REQ-023 GNTx, bx_vld=1: burst_cnt increments; when burst_len!=0, burst_cnt==burst_len-1 and by_vld=1 -> GNTy, else stay GNTx.
REQ-024 GNTx limit reached with by_vld=0 -> stay GNTx and restart burst_cnt at 0.
REQ-025 burst_cnt is 4 bits, clears on every state change and on entry to GNTx; when burst_len=0 it wraps 15->0 and never preempts.
REQ-026 last_owner updates to x on every cycle in GNTx.
REQ-027 Switch GNTx->GNTy occurs with no idle bubble.
REQ-028 dbg_en=0: next state IDLE regardless of requests, no acceptance while dbg_en=0, burst_cnt cleared; last_owner retained.
REQ-029 drop_cnt increments by the number (0,1,2) of sources with bx_vld=1 not accepted in that cycle, saturating at 2^CNTW-1 (no wrap, including +2 from max-1).
REQ-030 drop_clr=1 sets drop_cnt to 0 that cycle, taking priority over any increment.
REQ-031 Payload is never buffered; unaccepted source data is discarded.

Reset
REQ-032 arst_l low asynchronously forces: FSM IDLE, last_owner=1, burst_cnt=0, b0_gnt=0, b1_gnt=0, dbgbus_out=0, dbgbus_vld=0, dbgbus_src=0, drop_cnt=0.
REQ-033 Reset asserted mid-burst aborts the burst; first cycle after release behaves as IDLE with the tie going to source 0.
REQ-034 Release of arst_l is synchronised externally; block needs no internal synchroniser.

Structure
REQ-035 FSM state encodings and the DW default belong in the shared CTU package; burst_len and CNTW widths stay local.
REQ-036 One sub-module, ctu_dbgbus_arb_cnt: the saturating drop counter with clear.
REQ-037 Payload register uses the codebase's standard flop cells with scan disabled.

Verification
REQ-038 Reset, b0_vld=1 only, data 0x11..: first valid cycle dropped (drop_cnt=1), then GNT0, dbgbus_out follows b0_data one cycle later, dbgbus_src=0.
REQ-039 burst_len=3, both sources valid continuously from reset: grants 0,0,0,1,1,1,0... after IDLE; drop_cnt saturates at 255 with CNTW=8.
REQ-040 burst_len=0, both valid: GNT0 held 40 cycles with no preemption; b1 drops 1 per cycle.
REQ-041 GNT1 with b1_vld falling while b0_vld=1: GNT0 next cycle, dbgbus_vld continuous, no bubble.
REQ-042 dbg_en deasserted mid-burst: IDLE next cycle, dbgbus_vld=0 one cycle later; re-enable with both valid grants the source not last served.
REQ-043 drop_cnt=254 with two drops and drop_clr=1 same cycle -> 0; without clear -> 255 and holds.

Source files
------------

// File: rtl/ctu_dbgbus_arb_pkg.sv
// Shared definitions for the debug-bus arbiter: FSM state encodings and the
// default payload width.
package ctu_dbgbus_arb_pkg;

  localparam int DBG_DW = 40;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_GNT0 = 2'b01;
  localparam logic [1:0] ST_GNT1 = 2'b10;

endpackage

// File: rtl/ctu_dbgbus_arb_cnt.sv
// Saturating drop counter: adds 0..2 per cycle, sticks at all-ones,
// synchronous clear wins over any increment.
module ctu_dbgbus_arb_cnt #(
  parameter int CNTW = 8
) (
  input  logic            rclk,
  input  logic            arst_l,
  input  logic            clr,
  input  logic [1:0]      inc,
  output logic [CNTW-1:0] cnt
);

  localparam logic [CNTW:0] CNT_MAX = {1'b0, {CNTW{1'b1}}};

  logic [CNTW-1:0] cnt_reg;
  logic [CNTW-1:0] cnt_next;
  logic [CNTW:0]   sum;

  // One extra bit of headroom so +2 from max-1 is caught before it wraps.
  always_comb begin
    sum      = {1'b0, cnt_reg} + {{(CNTW - 1){1'b0}}, inc};
    cnt_next = sum[CNTW-1:0];
    if (clr) begin
      cnt_next = '0;
    end else if (sum > CNT_MAX) begin
      cnt_next = '1;
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/ctu_dbgbus_arb.sv
// Two-source debug-bus arbiter with per-source burst limit, registered
// payload output and a saturating count of dropped (ungranted) cycles.
module ctu_dbgbus_arb
  import ctu_dbgbus_arb_pkg::*;
#(
  parameter int DW   = DBG_DW,
  parameter int CNTW = 8
) (
  input  logic            rclk,
  input  logic            arst_l,
  input  logic            dbg_en,
  input  logic [3:0]      burst_len,
  input  logic [DW-1:0]   b0_data,
  input  logic            b0_vld,
  input  logic [DW-1:0]   b1_data,
  input  logic            b1_vld,
  input  logic            drop_clr,
  output logic            b0_gnt,
  output logic            b1_gnt,
  output logic [DW-1:0]   dbgbus_out,
  output logic            dbgbus_vld,
  output logic            dbgbus_src,
  output logic [CNTW-1:0] drop_cnt
);

  logic [1:0]    state_reg, state_next;
  logic [3:0]    burst_cnt_reg, burst_cnt_next;
  logic          last_owner_reg, last_owner_next;
  logic [DW-1:0] out_reg;
  logic          vld_reg, src_reg;

  logic          acc0, acc1;
  logic          own_vld, oth_vld;
  logic          limit_hit;
  logic [1:0]    other_state;
  logic [1:0]    drop_inc;

  assign b0_gnt = (state_reg == ST_GNT0);
  assign b1_gnt = (state_reg == ST_GNT1);

  assign acc0 = dbg_en & b0_gnt & b0_vld;
  assign acc1 = dbg_en & b1_gnt & b1_vld;

  assign drop_inc = {1'b0, b0_vld & ~acc0} + {1'b0, b1_vld & ~acc1};

  always_comb begin
    own_vld     = b1_gnt ? b1_vld : b0_vld;
    oth_vld     = b1_gnt ? b0_vld : b1_vld;
    other_state = b1_gnt ? ST_GNT0 : ST_GNT1;
    limit_hit   = (burst_len != 4'd0) && (burst_cnt_reg == (burst_len - 4'd1));

    state_next      = state_reg;
    burst_cnt_next  = '0;
    last_owner_next = last_owner_reg;
    if (b0_gnt) last_owner_next = 1'b0;
    if (b1_gnt) last_owner_next = 1'b1;

    if (!dbg_en) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // Tie goes to whichever source did not own the bus most recently.
          if (b0_vld && b1_vld)  state_next = last_owner_reg ? ST_GNT0 : ST_GNT1;
          else if (b0_vld)       state_next = ST_GNT0;
          else if (b1_vld)       state_next = ST_GNT1;
          else                   state_next = ST_IDLE;
        end
        ST_GNT0, ST_GNT1: begin
          if (!own_vld) begin
            state_next = oth_vld ? other_state : ST_IDLE;
          end else if (limit_hit) begin
            // Limit with no competitor: keep the bus, start a fresh burst.
            state_next = oth_vld ? other_state : state_reg;
          end else begin
            burst_cnt_next = burst_cnt_reg + 4'd1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_reg      <= ST_IDLE;
      burst_cnt_reg  <= '0;
      last_owner_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      burst_cnt_reg  <= burst_cnt_next;
      last_owner_reg <= last_owner_next;
    end
  end

  // Payload/source hold their last accepted value; only the valid drops.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      out_reg <= '0;
      vld_reg <= 1'b0;
      src_reg <= 1'b0;
    end else begin
      vld_reg <= acc0 | acc1;
      if (acc0) begin
        out_reg <= b0_data;
        src_reg <= 1'b0;
      end else if (acc1) begin
        out_reg <= b1_data;
        src_reg <= 1'b1;
      end
    end
  end

  assign dbgbus_out = out_reg;
  assign dbgbus_vld = vld_reg;
  assign dbgbus_src = src_reg;

  ctu_dbgbus_arb_cnt #(
    .CNTW (CNTW)
  ) u_drop_cnt (
    .rclk   (rclk),
    .arst_l (arst_l),
    .clr    (drop_clr),
    .inc    (drop_inc),
    .cnt    (drop_cnt)
  );

endmodule

// File: tb/tb_ctu_dbgbus_arb.sv
// Scoreboard bench for ctu_dbgbus_arb: directed scenarios plus random traffic
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_ctu_dbgbus_arb;

  localparam int DW   = 40;
  localparam int CNTW = 8;
  localparam int DMAX = (1 << CNTW) - 1;

  logic            rclk = 1'b0;
  logic            arst_l = 1'b0;
  logic            dbg_en = 1'b0;
  logic [3:0]      burst_len = 4'd0;
  logic [DW-1:0]   b0_data = '0;
  logic            b0_vld = 1'b0;
  logic [DW-1:0]   b1_data = '0;
  logic            b1_vld = 1'b0;
  logic            drop_clr = 1'b0;
  logic            b0_gnt, b1_gnt;
  logic [DW-1:0]   dbgbus_out;
  logic            dbgbus_vld, dbgbus_src;
  logic [CNTW-1:0] drop_cnt;

  ctu_dbgbus_arb #(.DW(DW), .CNTW(CNTW)) dut (
    .rclk       (rclk),
    .arst_l     (arst_l),
    .dbg_en     (dbg_en),
    .burst_len  (burst_len),
    .b0_data    (b0_data),
    .b0_vld     (b0_vld),
    .b1_data    (b1_data),
    .b1_vld     (b1_vld),
    .drop_clr   (drop_clr),
    .b0_gnt     (b0_gnt),
    .b1_gnt     (b1_gnt),
    .dbgbus_out (dbgbus_out),
    .dbgbus_vld (dbgbus_vld),
    .dbgbus_src (dbgbus_src),
    .drop_cnt   (drop_cnt)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    bit            vld;
    bit            src;
    logic [DW-1:0] out;
    int            drop;
    bit            g0;
    bit            g1;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: owner 0=none, 1=source0, 2=source1; used = grant cycles in burst.
  int            m_owner = 0;
  int            m_used  = 0;
  int            m_last  = 1;
  int            m_drop  = 0;
  logic [DW-1:0] m_out   = '0;
  bit            m_src   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  task automatic step(input bit rst, input bit en, input int bl, input bit v0, input bit v1,
                      input bit clr, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    exp_t e;
    int   acc, drops, nxt, me, other;
    bit   own, oth;
    @(negedge rclk);
    arst_l = !rst; dbg_en = en; burst_len = 4'(bl);
    b0_vld = v0; b1_vld = v1; b0_data = d0; b1_data = d1; drop_clr = clr;
    if (rst) begin
      m_owner = 0; m_used = 0; m_last = 1; m_drop = 0; m_out = '0; m_src = 1'b0;
    end else begin
      acc = -1;
      if (en && m_owner == 1 && v0) acc = 0;
      if (en && m_owner == 2 && v1) acc = 1;
      drops = ((v0 && acc != 0) ? 1 : 0) + ((v1 && acc != 1) ? 1 : 0);
      m_drop = clr ? 0 : ((m_drop + drops > DMAX) ? DMAX : m_drop + drops);
      if (acc >= 0) begin
        m_out = (acc == 0) ? d0 : d1;
        m_src = (acc == 1);
      end
      nxt = 0;
      if (!en) begin
        nxt = 0; m_used = 0;
      end else if (m_owner == 0) begin
        if (v0 && v1)  nxt = (m_last == 0) ? 2 : 1;
        else if (v0)   nxt = 1;
        else if (v1)   nxt = 2;
        m_used = 0;
      end else begin
        me    = m_owner;
        other = 3 - m_owner;
        own   = (me == 1) ? v0 : v1;
        oth   = (me == 1) ? v1 : v0;
        if (!own) begin
          nxt = oth ? other : 0; m_used = 0;
        end else if (bl != 0 && m_used + 1 == bl) begin
          nxt = oth ? other : me; m_used = 0;
        end else begin
          nxt = me; m_used = (m_used + 1) % 16;
        end
      end
      if (m_owner != 0) m_last = m_owner - 1;
      m_owner = nxt;
      e.vld = (acc >= 0);
    end
    if (rst) e.vld = 1'b0;
    e.src  = m_src;
    e.out  = m_out;
    e.drop = m_drop;
    e.g0   = (m_owner == 1);
    e.g1   = (m_owner == 2);
    exp_q.push_back(e);
  endtask

  // Monitor: one popped expectation per clock edge, sampled just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge rclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dbgbus_vld", 64'(dbgbus_vld), 64'(e.vld));
        chk("dbgbus_out", 64'(dbgbus_out), 64'(e.out));
        chk("dbgbus_src", 64'(dbgbus_src), 64'(e.src));
        chk("drop_cnt",   64'(drop_cnt),   64'(e.drop));
        chk("b0_gnt",     64'(b0_gnt),     64'(e.g0));
        chk("b1_gnt",     64'(b1_gnt),     64'(e.g1));
        if (e.vld)
          $display("t=%0t out=%0h src=%0d drop=%0d", $time, dbgbus_out, dbgbus_src, drop_cnt);
      end
    end
  end

  initial begin
    logic [DW-1:0] base;
    int bl;
    bit rs, en, v0, v1, cl;
    base = 40'h11;

    // Reset, then source 0 alone with an incrementing payload.
    repeat (2) step(1, 0, 0, 0, 0, 0, '0, '0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 0, 0, base + 40'(i), rnd_data());

    // burst_len=3 with both sources streaming; long enough to saturate drops.
    step(1, 0, 3, 0, 0, 0, '0, '0);
    for (int i = 0; i < 300; i++) step(0, 1, 3, 1, 1, 0, rnd_data(), rnd_data());

    // Unlimited bursts: source 0 never preempted.
    step(1, 0, 0, 0, 0, 0, '0, '0);
    for (int i = 0; i < 41; i++) step(0, 1, 0, 1, 1, 0, rnd_data(), rnd_data());

    // Owner 1 stops while source 0 waits: handover with no bubble.
    step(1, 0, 0, 0, 0, 0, '0, '0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 0, rnd_data(), rnd_data());
    for (int i = 0; i < 2; i++) step(0, 1, 0, 1, 1, 0, rnd_data(), rnd_data());
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 0, rnd_data(), rnd_data());

    // Disable mid-burst, then re-enable with both requesting.
    step(1, 0, 4, 0, 0, 0, '0, '0);
    for (int i = 0; i < 3; i++) step(0, 1, 4, 1, 1, 0, rnd_data(), rnd_data());
    for (int i = 0; i < 2; i++) step(0, 0, 4, 1, 1, 0, rnd_data(), rnd_data());
    for (int i = 0; i < 3; i++) step(0, 1, 4, 1, 1, 0, rnd_data(), rnd_data());

    // Drop counter to 254, clear against a +2, then saturate and hold.
    step(1, 0, 0, 0, 0, 0, '0, '0);
    for (int i = 0; i < 127; i++) step(0, 0, 0, 1, 1, 0, rnd_data(), rnd_data());
    step(0, 0, 0, 1, 1, 1, rnd_data(), rnd_data());
    for (int i = 0; i < 127; i++) step(0, 0, 0, 1, 1, 0, rnd_data(), rnd_data());
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 0, rnd_data(), rnd_data());

    // Random traffic with occasional resets, disables and clears.
    for (int i = 0; i < 2500; i++) begin
      if (i % 60 == 0) bl = $urandom_range(0, 5);
      rs = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 9) != 0);
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 2) != 0);
      cl = ($urandom_range(0, 49) == 0);
      step(rs, en, bl, v0, v1, cl, rnd_data(), rnd_data());
    end

    repeat (2) @(posedge rclk);
    #2;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
